// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   SHA-256 message-schedule expander. Loads one 512-bit block as 16
//   big-endian 32-bit words M[0..15] (word 0 first). It then emits the
//   schedule words W[0..ROUNDS-1], one per out_valid/out_ready handshake.
//   A 16-entry circular buffer holds the last 16 schedule words. W[t] for
//   t>=16 is written over W[t-16] once it is accepted.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid && ready are both high and abort is low. valid does not
//   depend on ready. out_word/out_idx come from registered state only.
//
//   Optional build macro: SCHED_STALL_CNT_EN adds the output stall_cnt. It
//   is a saturating 16-bit count of cycles with out_valid && !out_ready.
//   It is cleared on the 16th load accept and on reset.
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     abort           synchronous discard of the current block
//     in_valid/ready  message-word handshake, in_word = M[i]
//     out_valid/ready schedule-word handshake, out_word = W[t], out_idx = t
//     done            pulse on the final (t == ROUNDS-1) output handshake
//     stall_cnt       (SCHED_STALL_CNT_EN only) backpressure cycle counter

module right_rotator #(
    parameter int W = 32
) (
    input  logic [W-1:0]         din_i,
    input  logic [$clog2(W)-1:0] rotate_amt,
    output logic [W-1:0]         dout_o
);
    // A shift by W (rotate_amt == 0) gives zero, so the OR is still correct.
    assign dout_o = (din_i >> rotate_amt) | (din_i << (W - int'(rotate_amt)));
endmodule

module sha256_msg_schedule #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [CNT_W-1:0] out_idx,
    output logic             done
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    typedef enum logic {S_LOAD = 1'b0, S_EMIT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic [31:0]      buf_q [16];

    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [31:0]      wr_data;

    // Taps into the circular buffer. The 4-bit subtraction wraps mod 16.
    logic [3:0]  t_lo;
    logic [31:0] w_m2, w_m7, w_m15, w_m16;
    logic [31:0] r7, r18, r17, r19;
    logic [31:0] sig0, sig1, w_new;
    logic        past_16;

    assign t_lo    = t_q[3:0];
    assign w_m2    = buf_q[t_lo - 4'd2];
    assign w_m7    = buf_q[t_lo - 4'd7];
    assign w_m15   = buf_q[t_lo - 4'd15];
    assign w_m16   = buf_q[t_lo];
    assign past_16 = (t_q >= CNT_W'(16));

    right_rotator #(.W(32)) u_rot7  (.din_i(w_m15), .rotate_amt(5'd7),  .dout_o(r7));
    right_rotator #(.W(32)) u_rot18 (.din_i(w_m15), .rotate_amt(5'd18), .dout_o(r18));
    right_rotator #(.W(32)) u_rot17 (.din_i(w_m2),  .rotate_amt(5'd17), .dout_o(r17));
    right_rotator #(.W(32)) u_rot19 (.din_i(w_m2),  .rotate_amt(5'd19), .dout_o(r19));

    assign sig0  = r7 ^ r18 ^ (w_m15 >> 3);
    assign sig1  = r17 ^ r19 ^ (w_m2 >> 10);
    assign w_new = sig1 + w_m7 + sig0 + w_m16;

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_EMIT);
    assign out_idx   = t_q;
    // Forced to zero outside EMIT so the outputs do not expose buffer contents.
    assign out_word  = !out_valid ? 32'd0 : (past_16 ? w_new : w_m16);
    assign done      = out_valid && out_ready && !abort && (t_q == CNT_W'(ROUNDS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = in_word;
        if (abort) begin
            state_d = S_LOAD;
            cnt_d   = 4'd0;
            t_d     = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_d = S_EMIT;
                            t_d     = '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        // W[t-16] is dead once W[t] leaves, so reuse its slot.
                        if (past_16) begin
                            wr_en   = 1'b1;
                            wr_idx  = t_lo;
                            wr_data = w_new;
                        end
                        if (t_q == CNT_W'(ROUNDS - 1)) begin
                            state_d = S_LOAD;
                            cnt_d   = 4'd0;
                            t_d     = '0;
                        end else begin
                            t_d = t_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= 4'd0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_idx] <= wr_data;
    end

`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        load_last;

    assign load_last = in_ready && in_valid && !abort && (cnt_q == 4'd15);

    always_comb begin
        stall_d = stall_q;
        if (load_last)
            stall_d = 16'd0;
        else if (out_valid && !out_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 16'd0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule. dut64 uses ROUNDS=64 and dut17 uses
// ROUNDS=17. The reference model expands each loaded block into a plain
// W[] array using the textbook SHA-256 recurrence. The compare process then
// walks that array, one entry per output handshake.
module tb_sha256_msg_schedule;
  logic clk;
  logic rst_n;
  logic [1:0]       abort_s;
  logic [1:0]       in_valid_s;
  logic [1:0]       in_ready_s;
  logic [1:0][31:0] in_word_s;
  logic [1:0]       out_valid_s;
  logic [1:0]       out_ready_s;
  logic [1:0][31:0] out_word_s;
  logic [1:0][5:0]  out_idx_s;
  logic [1:0]       done_s;
  logic [1:0][15:0] stall_s;

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  sha256_msg_schedule #(.ROUNDS(64), .CNT_W(6)) dut64 (
    .clk(clk), .rst_n(rst_n), .abort(abort_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_word(in_word_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_word(out_word_s[0]),
    .out_idx(out_idx_s[0]), .done(done_s[0])
`ifdef SCHED_STALL_CNT_EN
    , .stall_cnt(stall_s[0])
`endif
  );

  sha256_msg_schedule #(.ROUNDS(17), .CNT_W(6)) dut17 (
    .clk(clk), .rst_n(rst_n), .abort(abort_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_word(in_word_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_word(out_word_s[1]),
    .out_idx(out_idx_s[1]), .done(done_s[1])
`ifdef SCHED_STALL_CNT_EN
    , .stall_cnt(stall_s[1])
`endif
  );

`ifndef SCHED_STALL_CNT_EN
  assign stall_s = '0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void expand(input logic [31:0] m[16], output logic [31:0] w[64]);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
  endfunction

  function automatic int rounds_of(input int d);
    return (d == 0) ? 64 : 17;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic        emitting [2];
  int          ld_cnt   [2];
  logic [31:0] ld_buf   [2][16];
  logic [31:0] exp_w    [2][64];
  int          exp_pos  [2];
  int          hs_cnt   [2];
  int          done_cnt [2];
  logic [15:0] m_stall  [2];
  logic [31:0] got_w    [64];
  logic        exp_done;

  initial begin
    for (int d = 0; d < 2; d++) begin
      emitting[d] = 1'b0; ld_cnt[d] = 0; exp_pos[d] = 0;
      hs_cnt[d] = 0; done_cnt[d] = 0; m_stall[d] = 16'd0;
    end
  end

  // Outputs are sampled on the falling edge. The inputs seen here are the
  // ones the next rising edge will act on, so the model advances afterwards.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        emitting[d] = 1'b0; ld_cnt[d] = 0; exp_pos[d] = 0; m_stall[d] = 16'd0;
      end else begin
        chk("in_ready", 64'(in_ready_s[d]), 64'(!emitting[d]));
        chk("out_valid", 64'(out_valid_s[d]), 64'(emitting[d]));
        exp_done = emitting[d] && out_ready_s[d] && !abort_s[d] &&
                   (exp_pos[d] == rounds_of(d) - 1);
        chk("done", 64'(done_s[d]), 64'(exp_done));
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_s[d]), 64'(m_stall[d]));
`endif
        if (emitting[d]) begin
          chk("out_word", 64'(out_word_s[d]), 64'(exp_w[d][exp_pos[d]]));
          chk("out_idx", 64'(out_idx_s[d]), 64'(exp_pos[d]));
          if (d == 0) got_w[exp_pos[0]] = out_word_s[0];
        end
        if (done_s[d]) done_cnt[d]++;
        if (emitting[d] && !out_ready_s[d] && m_stall[d] != 16'hFFFF) m_stall[d]++;
        if (abort_s[d]) begin
          emitting[d] = 1'b0; ld_cnt[d] = 0; exp_pos[d] = 0;
        end else if (!emitting[d] && in_valid_s[d]) begin
          ld_buf[d][ld_cnt[d]] = in_word_s[d];
          ld_cnt[d]++;
          if (ld_cnt[d] == 16) begin
            logic [31:0] m[16];
            logic [31:0] w[64];
            for (int i = 0; i < 16; i++) m[i] = ld_buf[d][i];
            expand(m, w);
            for (int i = 0; i < 64; i++) exp_w[d][i] = w[i];
            emitting[d] = 1'b1; exp_pos[d] = 0; ld_cnt[d] = 0; m_stall[d] = 16'd0;
          end
        end else if (emitting[d] && out_ready_s[d]) begin
          hs_cnt[d]++;
          exp_pos[d]++;
          if (exp_pos[d] == rounds_of(d)) begin
            emitting[d] = 1'b0; exp_pos[d] = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_block(input int d, input logic [31:0] m[16],
                            input int gap_after, input int gap_len);
    for (int i = 0; i < 16; i++) begin
      in_valid_s[d] = 1'b1;
      in_word_s[d]  = m[i];
      @(posedge clk); #1;
      if (i == gap_after) begin
        in_valid_s[d] = 1'b0;
        in_word_s[d]  = $urandom;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    in_valid_s[d] = 1'b0;
  endtask

  task automatic drain(input int d, input int stall_pct);
    int cyc = 0;
    while (emitting[d] && cyc < 2000) begin
      out_ready_s[d] = ($urandom_range(99) >= stall_pct);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready_s[d] = 1'b0;
    chk("drain_budget", 64'(cyc < 2000), 64'd1);
  endtask

  task automatic rand_block(output logic [31:0] m[16]);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_out_valid"}, 64'(out_valid_s[d]), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready_s[d]), 64'd1);
      chk({tag, "_done"}, 64'(done_s[d]), 64'd0);
      chk({tag, "_out_idx"}, 64'(out_idx_s[d]), 64'd0);
      chk({tag, "_out_word"}, 64'(out_word_s[d]), 64'd0);
`ifdef SCHED_STALL_CNT_EN
      chk({tag, "_stall_cnt"}, 64'(stall_s[d]), 64'd0);
`endif
    end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] abc [16];
  logic [31:0] blk [16];
  logic [31:0] wref [64];
  int          found;

  initial begin
    rst_n = 1'b0;
    abort_s = '0; in_valid_s = '0; in_word_s = '0; out_ready_s = '0;
    for (int i = 0; i < 16; i++) abc[i] = 32'd0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model itself with hand-computed values.
    expand(abc, wref);
    chk("model_w16", 64'(wref[16]), 64'h61626380);
    chk("model_w17", 64'(wref[17]), 64'h000F0000);
    chk("model_w18", 64'(wref[18]), 64'h7DA86405);

    // "abc" block, no backpressure.
    done_cnt[0] = 0;
    load_block(0, abc, -1, 0);
    drain(0, 0);
    chk("abc_done_count", 64'(done_cnt[0]), 64'd1);
    chk("abc_w16", 64'(got_w[16]), 64'h61626380);
    chk("abc_w17", 64'(got_w[17]), 64'h000F0000);
    chk("abc_w18", 64'(got_w[18]), 64'h7DA86405);
    chk("abc_w15", 64'(got_w[15]), 64'h00000018);

    // Same block under 50% random backpressure.
    done_cnt[0] = 0;
    load_block(0, abc, -1, 0);
    drain(0, 50);
    chk("bp_done_count", 64'(done_cnt[0]), 64'd1);

    // Gapped load: 3 idle cycles between words 7 and 8.
    rand_block(blk);
    load_block(0, blk, 7, 3);
    drain(0, 0);

    // Abort during LOAD together with an in_valid word, then a full block.
    for (int i = 0; i < 5; i++) begin
      in_valid_s[0] = 1'b1; in_word_s[0] = $urandom;
      @(posedge clk); #1;
    end
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    chk("abort_load_in_ready", 64'(in_ready_s[0]), 64'd1);

    // Abort at t=20 with out_ready high.
    rand_block(blk);
    done_cnt[0] = 0;
    load_block(0, blk, -1, 0);
    out_ready_s[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid_s[0] && out_idx_s[0] == 6'd20) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("abort_reach_t20", 64'(found), 64'd1);
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0; out_ready_s[0] = 1'b0;
    chk("abort_out_valid", 64'(out_valid_s[0]), 64'd0);
    chk("abort_in_ready", 64'(in_ready_s[0]), 64'd1);
    chk("abort_no_done", 64'(done_cnt[0]), 64'd0);
    rand_block(blk);
    load_block(0, blk, -1, 0);
    drain(0, 30);

    // Asynchronous reset in the middle of EMIT, between clock edges.
    rand_block(blk);
    load_block(0, blk, -1, 0);
    out_ready_s[0] = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    out_ready_s[0] = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 64'(in_ready_s[0]), 64'd1);
    rand_block(blk);
    load_block(0, blk, -1, 0);
    drain(0, 20);

    // Back-to-back blocks on the ROUNDS=17 instance.
    for (int b = 0; b < 2; b++) begin
      hs_cnt[1] = 0; done_cnt[1] = 0;
      if (b == 0) blk = abc; else rand_block(blk);
      load_block(1, blk, -1, 0);
      drain(1, 0);
      chk("r17_outputs", 64'(hs_cnt[1]), 64'd17);
      chk("r17_done_count", 64'(done_cnt[1]), 64'd1);
      chk("r17_in_ready_after_done", 64'(in_ready_s[1]), 64'd1);
    end

    // Random blocks with random gaps and random backpressure.
    for (int b = 0; b < 4; b++) begin
      done_cnt[0] = 0;
      rand_block(blk);
      load_block(0, blk, $urandom_range(14), $urandom_range(3));
      drain(0, $urandom_range(70));
      chk("rand_done_count", 64'(done_cnt[0]), 64'd1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
